vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_DISPLAY, default 480, visible lines per frame.
REQ-006 Parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 clk  input  1  system clock, 100 MHz; sole clock.
REQ-010 rst  input  1  reset, asynchronous, active-high.
REQ-011 p_tick  output  1  pixel-enable strobe, one clk wide.
REQ-012 xg  output  10  current pixel column, 0..H_TOTAL-1.
REQ-013 yg  output  10  current pixel row, 0..V_TOTAL-1.
REQ-014 hsync  output  1  horizontal sync, active-low.
REQ-015 vsync  output  1  vertical sync, active-low.
REQ-016 video_on  output  1  high while xg < H_DISPLAY and yg < V_DISPLAY.
REQ-017 frame_tick  output  1  one-clk pulse at start of each frame.

Function
REQ-018 H_TOTAL SHALL equal H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL SHALL equal V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
REQ-019 xg SHALL increment by 1 on each clk where p_tick is high and hold otherwise.
REQ-020 When xg = H_TOTAL-1 and p_tick is high, xg SHALL wrap to 0 on the next clk.
REQ-021 yg SHALL increment only on the clk where xg wraps, and hold otherwise.
REQ-022 When yg = V_TOTAL-1 and xg wraps, yg SHALL wrap to 0 on the same clk.
REQ-023 hsync SHALL be low exactly while H_DISPLAY+H_FRONT <= xg <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751), high otherwise.
REQ-024 vsync SHALL be low exactly while V_DISPLAY+V_FRONT <= yg <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491), high otherwise.
REQ-025 hsync, vsync and video_on SHALL be registered and aligned with the xg/yg values they describe (zero cycles of skew between them).
REQ-026 frame_tick SHALL pulse high for exactly one clk, coincident with the p_tick on which xg=0 and yg=0 are first presented after a wrap.
REQ-027 xg and yg SHALL never present values >= H_TOTAL or >= V_TOTAL respectively.
REQ-028 Downstream pixel blocks SHALL be able to treat xg/yg as stable for every clk between successive p_tick strobes.

Reset
REQ-029 While rst is high: xg=0, yg=0, hsync=1, vsync=1, video_on=0, frame_tick=0, p_tick=0, divider counter=0.
REQ-030 Assertion of rst mid-line or mid-frame SHALL force reset values immediately, without waiting for clk.
REQ-031 After rst deasserts, the first p_tick SHALL restart counting from xg=0,yg=0; frame_tick SHALL NOT pulse for the reset-state position itself.

Configuration
REQ-032 Macro VGA_TICK_DIV_EN SHALL select the pixel-rate source.
REQ-033 With VGA_TICK_DIV_EN defined: a 2-bit divider SHALL assert p_tick on every 4th clk (25 MHz), first assertion on the 4th clk after reset release.
REQ-034 Without VGA_TICK_DIV_EN: p_tick SHALL be tied high after reset (one pixel per clk) and no divider logic SHALL exist.

Verification
REQ-035 Reset release, VGA_TICK_DIV_EN defined -> p_tick high on clks 4, 8, 12...; xg 0->1 at clk 8.
REQ-036 Run to xg=799, yg=0, then one p_tick -> xg=0, yg=1, hsync=1, frame_tick=0.
REQ-037 Run to xg=799, yg=524, then one p_tick -> xg=0, yg=0, frame_tick high for exactly one clk.
REQ-038 Sweep one full line -> hsync low for exactly 96 pixels (xg 656..751), video_on high for exactly 640 pixels.
REQ-039 Sweep one full frame -> vsync low for exactly 2 lines (yg 490..491), 420,000 p_ticks between frame_tick pulses.
REQ-040 Assert rst asynchronously at xg=300, yg=200 -> all outputs at reset values before next clk edge; count restarts from 0,0 after release.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with registered syncs, video enable and frame strobe.
// Define VGA_TICK_DIV_EN to derive the pixel strobe from a divide-by-4 of clk; otherwise one pixel per clk.
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       p_tick,
    output logic [9:0] xg,
    output logic [9:0] yg,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_tick
);
    localparam logic [9:0] X_LAST = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] Y_LAST = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
    localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic       w_en;
    logic       w_xwrap;
    logic       w_ywrap;
    logic [9:0] w_xn;
    logic [9:0] w_yn;
    logic       r_started;
    logic       r_tick;
    logic       r_frame;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_von;
    logic [9:0] r_x;
    logic [9:0] r_y;

`ifdef VGA_TICK_DIV_EN
    logic [1:0] r_div;

    // Free-running divide-by-4; the strobe fires on the 4th clk after reset release
    always_ff @(posedge clk or posedge rst)
        if (rst) r_div <= 2'd0;
        else     r_div <= r_div + 2'd1;

    assign w_en = r_div == 2'd3;
`else
    assign w_en = 1'b1;
`endif

    // Next raster position: the first strobe after reset presents the origin, later ones advance
    always_comb begin
        w_xwrap = r_x == X_LAST;
        w_ywrap = r_y == Y_LAST;
        w_xn    = (!r_started || w_xwrap) ? 10'd0 : r_x + 10'd1;
        w_yn    = !r_started ? 10'd0 : !w_xwrap ? r_y : w_ywrap ? 10'd0 : r_y + 10'd1;
    end

    // Position and its decoded syncs/enable update together so they never skew
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_started <= 1'b0;
            r_tick    <= 1'b0;
            r_frame   <= 1'b0;
            r_x       <= 10'd0;
            r_y       <= 10'd0;
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_von     <= 1'b0;
        end else begin
            r_tick  <= w_en;
            r_frame <= w_en && r_started && w_xwrap && w_ywrap;
            if (w_en) begin
                r_started <= 1'b1;
                r_x       <= w_xn;
                r_y       <= w_yn;
                r_hsync   <= !(w_xn >= HS_BEG && w_xn < HS_END);
                r_vsync   <= !(w_yn >= VS_BEG && w_yn < VS_END);
                r_von     <= w_xn < H_VIS && w_yn < V_VIS;
            end
        end

    assign p_tick     = r_tick;
    assign frame_tick = r_frame;
    assign xg         = r_x;
    assign yg         = r_y;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign video_on   = r_von;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random-reset bench comparing two geometries against an arithmetic raster model.
module tb_vga_timing_gen;
`ifdef VGA_TICK_DIV_EN
    localparam int DIV = 4;
`else
    localparam int DIV = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_p, a_f, a_h, a_v, a_von;
    logic [9:0] a_x, a_y;
    logic       b_p, b_f, b_h, b_v, b_von;
    logic [9:0] b_x, b_y;

    vga_timing_gen u_dflt (
        .clk(clk), .rst(rst), .p_tick(a_p), .xg(a_x), .yg(a_y),
        .hsync(a_h), .vsync(a_v), .video_on(a_von), .frame_tick(a_f)
    );

    vga_timing_gen #(
        .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
        .V_DISPLAY(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(4)
    ) u_small (
        .clk(clk), .rst(rst), .p_tick(b_p), .xg(b_x), .yg(b_y),
        .hsync(b_h), .vsync(b_v), .video_on(b_von), .frame_tick(b_f)
    );

    int cyc;
    always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Raster from first principles: pixel n = strobes since release minus one
    function automatic logic [24:0] model(input int c, input logic r, input int hd, input int hf,
                                          input int hs, input int hb, input int vd, input int vf,
                                          input int vs, input int vb);
        int ht, vt, t, n, x, y;
        logic p, f, h, v, von;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        t  = c / DIV;
        if (r || t == 0) return {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0};
        n   = t - 1;
        x   = n % ht;
        y   = (n / ht) % vt;
        p   = (c % DIV) == 0;
        f   = p && n > 0 && (n % (ht * vt)) == 0;
        h   = !(x >= hd + hf && x < hd + hf + hs);
        v   = !(y >= vd + vf && y < vd + vf + vs);
        von = x < hd && y < vd;
        return {p, f, h, v, von, 10'(x), 10'(y)};
    endfunction

    int  hl, vis, gap, vlow;
    bit  line_done, seen_ft;

    task automatic clear_stats();
        hl = 0; vis = 0; gap = 0; vlow = 0; line_done = 0; seen_ft = 0;
    endtask

    task automatic sample();
        check("dflt", {7'd0, a_p, a_f, a_h, a_v, a_von, a_x, a_y},
              {7'd0, model(cyc, rst, 640, 16, 96, 48, 480, 10, 2, 33)});
        check("small", {7'd0, b_p, b_f, b_h, b_v, b_von, b_x, b_y},
              {7'd0, model(cyc, rst, 16, 4, 6, 5, 12, 3, 2, 4)});
    endtask

    task automatic stats();
        if (rst) begin
            clear_stats();
            return;
        end
        if (a_p) begin
            if (a_y == 10'd1) begin
                hl  += int'(!a_h);
                vis += int'(a_von);
            end
            if (a_y == 10'd2 && a_x == 10'd0 && !line_done) begin
                check("hsync_low_px", hl, 96);
                check("video_on_px", vis, 640);
                line_done = 1;
            end
        end
        if (b_p) begin
            if (b_f) begin
                check("frame_pos", {22'd0, b_x, b_y}, 0);
                if (seen_ft) begin
                    check("frame_gap", gap, 651);
                    check("vsync_low_lines", vlow / 31, 2);
                end
                seen_ft = 1;
                gap = 1;
                vlow = 0;
            end else begin
                gap++;
                vlow += int'(!b_v);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        stats();
    endtask

    task automatic async_reset();
        @(posedge clk);
        #($urandom_range(1, 3));
        rst = 1'b1;
        #1;
        sample();
        clear_stats();
        repeat ($urandom_range(1, 3)) step();
        rst = 1'b0;
    endtask

    initial begin
        bit found;
        clear_stats();
        repeat (3) step();
        rst = 1'b0;
        repeat (DIV * 2500) step();
        for (int s = 0; s < 3; s++) begin
            async_reset();
            repeat ($urandom_range(200, DIV * 1800)) step();
        end
        async_reset();
        found = 0;
        for (int i = 0; i < DIV * 1000 && !found; i++) begin
            step();
            found = a_x == 10'd300 && !rst;
        end
        check("reach_x300", {31'd0, found}, 1);
        async_reset();
        repeat (DIV * 900) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
